pdm_modulator: RTL and testbench

PDM_MODULATOR -- requirements
Module: pdm_modulator

---
 rtl/pdm_modulator.sv | 131 +++++++++++++
 tb/tb_pdm_modulator.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_modulator.sv
`default_nettype none
// pdm_modulator: PCM-to-PDM second-order sigma-delta with a generated bit clock
// and a one-deep sample holding register. Revision 1.0
module pdm_modulator #(
  parameter int DIV   = 16,
  parameter int OSR   = 64,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             pdm_clk,
  output logic             pdm_out,
  output logic             sample_tick,
  output logic             underrun
);

  localparam int DW = $clog2(DIV);
  localparam int BW = $clog2(OSR);
  localparam int IW = WIDTH + 4;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] OSR_LAST = BW'(OSR - 1);

  localparam logic signed [IW:0]   FB_POS = {{(IW+1-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [IW:0]   FB_NEG = {{(IW+2-WIDTH){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [IW-1:0] I_MAX  = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] I_MIN  = {1'b1, {(IW-1){1'b0}}};

  logic [DW-1:0]          div_cnt;
  logic [BW-1:0]          bit_cnt;
  logic signed [WIDTH-1:0] cur;
  logic signed [WIDTH-1:0] nxt;
  logic                   nxt_valid;
  logic signed [IW-1:0]   i1;
  logic signed [IW-1:0]   i2;

  logic                   div_wrap;
  logic                   step;
  logic                   bit_wrap;
  logic                   handshake;
  logic signed [IW:0]     fb;
  logic signed [IW:0]     cur_ext;
  logic signed [IW:0]     sum1;
  logic signed [IW:0]     sum2;
  logic signed [IW-1:0]   i1_next;
  logic signed [IW-1:0]   i2_next;

  // Sums carry one guard bit, so a mismatch of the top two bits means overflow.
  function automatic logic signed [IW-1:0] sat(input logic signed [IW:0] v);
    if (v[IW] != v[IW-1]) begin
      return v[IW] ? I_MIN : I_MAX;
    end
    return v[IW-1:0];
  endfunction

  assign div_wrap  = (div_cnt == DIV_LAST);
  assign step      = div_wrap && pdm_clk;
  assign bit_wrap  = step && (bit_cnt == OSR_LAST);
  assign in_ready  = enable && !nxt_valid;
  assign handshake = in_valid && in_ready;

  always_comb begin
    fb      = pdm_out ? FB_POS : FB_NEG;
    cur_ext = {{(IW+1-WIDTH){cur[WIDTH-1]}}, cur};
    sum1    = {i1[IW-1], i1} + cur_ext - fb;
    i1_next = sat(sum1);
    sum2    = {i2[IW-1], i2} + {i1_next[IW-1], i1_next} - fb;
    i2_next = sat(sum2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      pdm_clk     <= 1'b0;
      pdm_out     <= 1'b0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
      cur         <= '0;
      nxt         <= '0;
      nxt_valid   <= 1'b0;
      i1          <= '0;
      i2          <= '0;
    end else if (!enable) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      pdm_clk     <= 1'b0;
      pdm_out     <= 1'b0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
      cur         <= '0;
      nxt         <= '0;
      nxt_valid   <= 1'b0;
      i1          <= '0;
      i2          <= '0;
    end else begin
      sample_tick <= 1'b0;
      div_cnt     <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) begin
        pdm_clk <= ~pdm_clk;
      end
      // The modulator always uses the cur in effect before this edge.
      if (step) begin
        i1      <= i1_next;
        i2      <= i2_next;
        pdm_out <= ~i2_next[IW-1];
        bit_cnt <= bit_wrap ? '0 : bit_cnt + 1'b1;
      end
      if (bit_wrap) begin
        if (nxt_valid) begin
          cur         <= nxt;
          nxt_valid   <= 1'b0;
          sample_tick <= 1'b1;
        end else begin
          underrun <= 1'b1;
        end
      end
      // in_ready excludes a full holding register, so this never races the move above.
      if (handshake) begin
        nxt       <= in_data;
        nxt_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pdm_modulator.sv
`default_nettype none
// tb_pdm_modulator: directed self-checking bench for pdm_modulator (DIV=16, OSR=64, WIDTH=16).
module tb_pdm_modulator;
  localparam int DIV   = 16;
  localparam int OSR   = 64;
  localparam int WIDTH = 16;
  localparam int BITP  = 2 * DIV;

  logic             clk      = 1'b0;
  logic             rst      = 1'b0;
  logic             enable   = 1'b0;
  logic [WIDTH-1:0] in_data  = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             pdm_clk;
  logic             pdm_out;
  logic             sample_tick;
  logic             underrun;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pdm_modulator #(.DIV(DIV), .OSR(OSR), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pdm_clk     (pdm_clk),
    .pdm_out     (pdm_out),
    .sample_tick (sample_tick),
    .underrun    (underrun)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset, then release with enable high; the next rising edge is edge 1.
  task automatic start(input logic [WIDTH-1:0] data, input logic valid);
    rst = 1'b0; enable = 1'b0; in_valid = 1'b0;
    tick(2);
    rst = 1'b1; enable = 1'b1; in_data = data; in_valid = valid;
  endtask

  task automatic count_ones(input int nsteps, output int ones);
    ones = 0;
    repeat (nsteps) begin
      tick(BITP);
      if (pdm_out === 1'b1) ones++;
    end
  endtask

  task automatic test_reset;
    tick(2);
    checks++;
    if ({pdm_clk, pdm_out, sample_tick, underrun} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 0000", {pdm_clk, pdm_out, sample_tick, underrun});
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_disabled: got %b expected 0", in_ready);
    end
    enable = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_enabled: got %b expected 1", in_ready);
    end
    enable = 1'b0;
  endtask

  task automatic test_clock_timing;
    logic prev_clk, prev_out;
    int   bad, changes;
    bad = 0; changes = 0;
    start('0, 1'b0);
    prev_clk = 1'b0; prev_out = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      tick(1);
      if (pdm_out !== prev_out) begin
        changes++;
        if (!(prev_clk === 1'b1 && pdm_clk === 1'b0)) bad++;
      end
      prev_clk = pdm_clk; prev_out = pdm_out;
      if (cyc == 15 || cyc == 16 || cyc == 32 || cyc == 48 || cyc == 64) begin
        checks++;
        if (pdm_clk !== ((cyc == 16 || cyc == 48) ? 1'b1 : 1'b0)) begin
          failures++;
          $display("FAIL pdm_clk_edge_%0d: got %b expected %b", cyc, pdm_clk, (cyc == 16 || cyc == 48));
        end
      end
      if (cyc == 31 || cyc == 32 || cyc == 96 || cyc == 128 || cyc == 160) begin
        checks++;
        if (pdm_out !== ((cyc == 32 || cyc == 128) ? 1'b1 : 1'b0)) begin
          failures++;
          $display("FAIL pdm_out_edge_%0d: got %b expected %b", cyc, pdm_out, (cyc == 32 || cyc == 128));
        end
      end
    end
    checks++;
    if (bad != 0 || changes == 0) begin
      failures++;
      $display("FAIL pdm_out_on_fall: bad=%0d changes=%0d expected bad=0 changes>0", bad, changes);
    end
  endtask

  task automatic test_zero_input;
    int ones;
    start('0, 1'b1);
    count_ones(OSR, ones);
    checks++;
    if (ones < 30 || ones > 34) begin
      failures++;
      $display("FAIL zero_window1: got %0d ones expected 30..34", ones);
    end
    count_ones(OSR, ones);
    checks++;
    if (ones < 30 || ones > 34) begin
      failures++;
      $display("FAIL zero_window2: got %0d ones expected 30..34", ones);
    end
  endtask

  task automatic test_full_scale_pos;
    int ones;
    start(16'h7FFF, 1'b1);
    tick(OSR * BITP);
    count_ones(OSR, ones);
    checks++;
    if (ones < 62) begin
      failures++;
      $display("FAIL pos_window1: got %0d ones expected >=62", ones);
    end
    count_ones(OSR, ones);
    checks++;
    if (ones < 62) begin
      failures++;
      $display("FAIL pos_window2: got %0d ones expected >=62", ones);
    end
    checks++;
    if (int'(dut.i2) != 524287) begin
      failures++;
      $display("FAIL pos_i2_sat: got %0d expected 524287", int'(dut.i2));
    end
    checks++;
    if (int'(dut.i1) != 65408) begin
      failures++;
      $display("FAIL pos_i1: got %0d expected 65408", int'(dut.i1));
    end
  endtask

  task automatic test_full_scale_neg;
    int ones;
    start(16'h8000, 1'b1);
    tick(OSR * BITP);
    count_ones(OSR, ones);
    checks++;
    if (ones > 2) begin
      failures++;
      $display("FAIL neg_window1: got %0d ones expected <=2", ones);
    end
    count_ones(OSR, ones);
    checks++;
    if (ones > 2) begin
      failures++;
      $display("FAIL neg_window2: got %0d ones expected <=2", ones);
    end
    checks++;
    if (int'(dut.i2) != -524288) begin
      failures++;
      $display("FAIL neg_i2_sat: got %0d expected -524288", int'(dut.i2));
    end
    checks++;
    if (int'(dut.i1) != -65536) begin
      failures++;
      $display("FAIL neg_i1: got %0d expected -65536", int'(dut.i1));
    end
  endtask

  task automatic test_back_to_back;
    int ticks, first_tick, last_tick, ready_cnt, under_seen;
    ticks = 0; first_tick = -1; last_tick = -1; ready_cnt = 0; under_seen = 0;
    start(16'h1234, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hs_ready_initial: got %b expected 1", in_ready);
    end
    for (int cyc = 1; cyc <= 6200; cyc++) begin
      tick(1);
      if (sample_tick === 1'b1) begin
        ticks++;
        if (first_tick < 0) first_tick = cyc;
        last_tick = cyc;
      end
      if (in_ready === 1'b1) ready_cnt++;
      if (underrun !== 1'b0) under_seen++;
      if (cyc == 2048) begin
        checks++;
        if (dut.cur !== 16'h1234) begin
          failures++;
          $display("FAIL hs_cur_loaded: got %h expected 1234", dut.cur);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (ticks != 3 || first_tick != 2048 || last_tick != 6144) begin
      failures++;
      $display("FAIL hs_sample_tick: got n=%0d first=%0d last=%0d expected n=3 first=2048 last=6144",
               ticks, first_tick, last_tick);
    end
    checks++;
    if (ready_cnt != 3) begin
      failures++;
      $display("FAIL hs_ready_cycles: got %0d expected 3", ready_cnt);
    end
    checks++;
    if (under_seen != 0) begin
      failures++;
      $display("FAIL hs_no_underrun: got %0d underrun cycles expected 0", under_seen);
    end
  endtask

  task automatic test_underrun;
    start('0, 1'b0);
    tick(OSR * BITP - 1);
    checks++;
    if (underrun !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ur_before_wrap: got underrun=%b ready=%b expected 0 1", underrun, in_ready);
    end
    // Offer a sample exactly on the wrap step: it lands in nxt, not cur.
    in_data = 16'h0ABC; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    checks++;
    if (underrun !== 1'b1 || sample_tick !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ur_wrap: got underrun=%b tick=%b ready=%b expected 1 0 0", underrun, sample_tick, in_ready);
    end
    checks++;
    if (dut.cur !== 16'h0000) begin
      failures++;
      $display("FAIL ur_cur_kept: got %h expected 0000", dut.cur);
    end
    tick(OSR * BITP);
    checks++;
    if (sample_tick !== 1'b1 || underrun !== 1'b1 || dut.cur !== 16'h0ABC) begin
      failures++;
      $display("FAIL ur_next_wrap: got tick=%b underrun=%b cur=%h expected 1 1 0abc", sample_tick, underrun, dut.cur);
    end
    enable = 1'b0;
    tick(1);
    checks++;
    if (underrun !== 1'b0 || pdm_clk !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ur_enable_clear: got underrun=%b pdm_clk=%b ready=%b expected 0 0 0", underrun, pdm_clk, in_ready);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_sample;
    start('0, 1'b1);
    tick(1008);
    checks++;
    if (pdm_clk !== 1'b1 || pdm_out !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_pre_reset: got clk=%b out=%b ready=%b expected 1 1 0", pdm_clk, pdm_out, in_ready);
    end
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if ({pdm_clk, pdm_out, sample_tick, underrun} !== 4'b0000 || dut.nxt_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_async_clear: got outs=%b nxt_valid=%b ready=%b expected 0000 0 1",
               {pdm_clk, pdm_out, sample_tick, underrun}, dut.nxt_valid, in_ready);
    end
    tick(2);
    rst = 1'b1;
    tick(15);
    checks++;
    if (pdm_clk !== 1'b0) begin
      failures++;
      $display("FAIL mid_restart_15: got %b expected 0", pdm_clk);
    end
    tick(1);
    checks++;
    if (pdm_clk !== 1'b1) begin
      failures++;
      $display("FAIL mid_restart_16: got %b expected 1", pdm_clk);
    end
  endtask

  initial begin
    test_reset;
    test_clock_timing;
    test_zero_input;
    test_full_scale_pos;
    test_full_scale_neg;
    test_back_to_back;
    test_underrun;
    test_reset_mid_sample;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
